// File: rtl/mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2^MUL_STEP shift-add multiplier,
// restoring divider, valid/ready handshake with passthrough tag and flush.
module mdu_iter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 1,
  parameter int unsigned TAG_W    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  res_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int unsigned ACC_W = 2 * XLEN + MUL_STEP;
  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] MUL_N = CNT_W'(XLEN / MUL_STEP);
  localparam logic [CNT_W-1:0] DIV_N = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic [XLEN-1:0]    a_q;
  logic [2:0]         op_q;
  logic               sa_q, sb_q, byp_q;
  logic [XLEN-1:0]    res_q;
  logic [TAG_W-1:0]   tag_q;

  logic               accept;
  logic               a_sgn, b_sgn;
  logic [XLEN-1:0]    a_mag, b_mag;
  logic               div_zero, div_ovf, special;
  logic [XLEN-1:0]    spec_res;

  assign accept = in_valid_i & in_ready_o & ~flush_i;

  // Operand decode at accept: effective signs, magnitudes and bypass cases.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op_i)
      3'd1, 3'd4, 3'd6: begin
        a_sgn = rs1_i[XLEN-1];
        b_sgn = rs2_i[XLEN-1];
      end
      3'd2:    a_sgn = rs1_i[XLEN-1];
      default: ;
    endcase
    a_mag    = a_sgn ? -rs1_i : rs1_i;
    b_mag    = b_sgn ? -rs2_i : rs2_i;
    div_zero = (rs2_i == '0);
    div_ovf  = ~op_i[0] & (rs1_i == MIN_NEG) & (rs2_i == '1);
    special  = op_i[2] & (div_zero | div_ovf);
    if (div_zero) spec_res = op_i[1] ? rs1_i : '1;
    else          spec_res = op_i[1] ? '0 : rs1_i;
  end

  logic [XLEN+MUL_STEP-1:0] mul_sum;
  logic [ACC_W-1:0]         mul_next, div_next, step_next;
  logic [XLEN:0]            r_sh, r_diff;

  // Mul: acc = {partial product, remaining multiplier bits}, shifted right each step.
  // Div: acc[2X-1:X] = partial remainder, acc[X-1:0] = dividend shifting into quotient.
  always_comb begin
    mul_sum  = acc_q[ACC_W-1:XLEN]
             + ({{MUL_STEP{1'b0}}, a_q} * {{XLEN{1'b0}}, acc_q[MUL_STEP-1:0]});
    mul_next = {mul_sum, acc_q[XLEN-1:0]} >> MUL_STEP;
    r_sh     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    r_diff   = r_sh - {1'b0, a_q};
    if (!r_diff[XLEN])
      div_next = {{MUL_STEP{1'b0}}, r_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      div_next = {{MUL_STEP{1'b0}}, r_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    step_next = op_q[2] ? div_next : mul_next;
  end

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot, rem, fix_res;

  always_comb begin
    prod   = acc_q[2*XLEN-1:0];
    prod_s = (sa_q ^ sb_q) ? -prod : prod;
    quot   = acc_q[XLEN-1:0];
    rem    = acc_q[2*XLEN-1:XLEN];
    if (byp_q)         fix_res = acc_q[XLEN-1:0];
    else if (op_q[2])  fix_res = op_q[1] ? (sa_q ? -rem : rem)
                                         : ((sa_q ^ sb_q) ? -quot : quot);
    else if (op_q == 3'd0) fix_res = prod_s[XLEN-1:0];
    else               fix_res = prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = special ? FIX : CALC;
      CALC:    if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      acc_q <= '0;
      a_q   <= '0;
      op_q  <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      byp_q <= 1'b0;
      res_q <= '0;
      tag_q <= '0;
    end else if (accept) begin
      op_q  <= op_i;
      tag_q <= tag_i;
      sa_q  <= a_sgn;
      sb_q  <= b_sgn;
      byp_q <= special;
      a_q   <= op_i[2] ? b_mag : a_mag;
      cnt_q <= op_i[2] ? DIV_N : MUL_N;
      if (special)      acc_q <= ACC_W'(spec_res);
      else if (op_i[2]) acc_q <= ACC_W'(a_mag);
      else              acc_q <= ACC_W'(b_mag);
    end else if (state_q == CALC) begin
      acc_q <= step_next;
      cnt_q <= cnt_q - CNT_W'(1);
    end else if (state_q == FIX) begin
      res_q <= fix_res;
    end
  end

  assign res_o = res_q;
  assign tag_o = tag_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed RV32M cases, random ops against an
// arithmetic reference, backpressure, flush and mid-operation reset.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_valid4, out_ready, one;
  logic        in_ready, out_valid, in_ready4, out_valid4;
  logic [2:0]  op;
  logic [31:0] rs1, rs2, res, res4;
  logic [3:0]  tag, tag_out, tag4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mdu_iter #(.XLEN(32), .MUL_STEP(1), .TAG_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .tag_i(tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .res_o(res), .tag_o(tag_out)
  );

  mdu_iter #(.XLEN(32), .MUL_STEP(4), .TAG_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid4), .in_ready_o(in_ready4),
    .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .tag_i(tag),
    .out_valid_o(out_valid4), .out_ready_i(one),
    .res_o(res4), .tag_o(tag4)
  );

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] pu;
    longint      ps;
    int          sa, sb;
    sa = a;
    sb = b;
    pu = {32'b0, a} * {32'b0, b};
    case (o)
      3'd0: return pu[31:0];
      3'd1: begin ps = longint'(sa) * longint'(sb); return ps[63:32]; end
      3'd2: begin ps = longint'(sa) * longint'({32'b0, b}); return ps[63:32]; end
      3'd3: return pu[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    return o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tg, input int hold);
    logic [31:0] e;
    int          k, lat;
    e   = ref_res(o, a, b);
    lat = is_special(o, a, b) ? 2 : 34;
    @(negedge clk);
    chk("ready_before_op", in_ready, 1);
    op = o; rs1 = a; rs2 = b; tag = tg;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); rs1 = $urandom; rs2 = $urandom; tag = 4'($urandom);
    k = 0;
    while (out_valid !== 1'b1 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", 64'(k + 1), 64'(lat));
    chk("result", res, e);
    chk("tag", tag_out, tg);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_result", res, e);
      chk("hold_tag", tag_out, tg);
      chk("hold_not_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_ready", in_ready, 1);
    chk("release_valid", out_valid, 0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          sel, k, seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0;
    out_ready = 1'b0; one = 1'b1; op = '0; rs1 = '0; rs2 = '0; tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_ready", in_ready, 1);
    chk("reset_valid", out_valid, 0);
    chk("reset_res", res, 0);
    chk("reset_tag", tag_out, 0);

    run_op(3'd0, 32'd7,        32'hFFFF_FFFD, 4'h1, 0);
    chk("mul_directed", res, 32'hFFFF_FFEB);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 4'h2, 0);
    chk("mulh_directed", res, 32'h4000_0000);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h3, 0);
    chk("mulhu_directed", res, 32'hFFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h4, 0);
    chk("mulhsu_directed", res, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 4'h5, 0);
    chk("div_directed", res, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 4'h6, 0);
    chk("rem_directed", res, 32'hFFFF_FFFF);
    run_op(3'd5, 32'hFFFF_FFFF, 32'h10, 4'h7, 0);
    chk("divu_directed", res, 32'h0FFF_FFFF);
    run_op(3'd7, 32'hFFFF_FFFF, 32'h10, 4'h8, 0);
    chk("remu_directed", res, 32'hF);
    for (int o = 4; o < 8; o++) run_op(3'(o), 32'd5, 32'd0, 4'(o), 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'h9, 0);
    chk("div_ovf", res, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'hA, 0);
    chk("rem_ovf", res, 32'h0);

    run_op(3'd4, 32'd1000, 32'hFFFF_FFF9, 4'hB, 10);
    run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 4'hC, 0);

    for (int n = 0; n < 30; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if (sel == 2) rb = $urandom_range(1, 20);
      run_op(ro, ra, rb, 4'($urandom), $urandom_range(0, 2));
    end

    // Flush four edges after accept
    @(negedge clk);
    op = 3'd1; rs1 = 32'h1111_1111; rs2 = 32'h2222_2222; tag = 4'h3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    chk("flush_no_valid", 64'(seen), 0);

    @(negedge clk);
    op = 3'd5; rs1 = 32'd50; rs2 = 32'd7; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_blocks_accept", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    chk("flush_accept_no_valid", 64'(seen), 0);

    @(negedge clk);
    op = 3'd0; rs1 = 32'h0001_2345; rs2 = 32'h0000_0FED; tag = 4'h6; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    k = 0;
    while (out_valid4 !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("step4_latency", 64'(k + 1), 10);
    chk("step4_result", res4, ref_res(3'd0, 32'h0001_2345, 32'h0000_0FED));
    chk("step4_tag", tag4, 4'h6);

    run_op(3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4'hE, 0);
    @(negedge clk);
    op = 3'd0; rs1 = 32'd3; rs2 = 32'd9; tag = 4'h5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_res", res, 0);
    chk("rst_mid_tag", tag_out, 0);
    chk("rst_mid_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Parametrised iterative multiply/divide unit; the multi-cycle companion to the single-cycle integer ALU, executing the RV32M/RV64M op set. It accepts one op through a valid/ready handshake, iterates in a shift-add multiplier or a restoring divider, and returns the result with a passthrough tag. Width is generalised by XLEN and multiplier throughput by MUL_STEP. It supports flush for mispredict/exception recovery.

Parameters:
XLEN, 32, operand/result width; must be a multiple of MUL_STEP.
MUL_STEP, 1, multiplier bits retired per cycle; legal values are 1, 2, 4, 8.
TAG_W, 4, width of the opaque tag carried from input to output.

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
flush_i  in  1  abort any op in flight; drop any pending result
in_valid_i  in  1  op request valid
in_ready_o  out  1  unit idle; able to accept
op_i  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_i  in  XLEN  operand A (dividend/multiplicand)
rs2_i  in  XLEN  operand B (divisor/multiplier)
tag_i  in  TAG_W  request tag
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
res_o  out  XLEN  result
tag_o  out  TAG_W  tag of the result

Behaviour:
- One clock; reset is synchronous and active-low. While rst_ni=0 at a rising edge:
  - state goes to IDLE; counter, res_o and tag_o clear to 0; out_valid_o=0.
  - in_ready_o is 1 from the first cycle after reset.
- FSM states: IDLE, CALC, FIX, DONE. in_ready_o = (state==IDLE); out_valid_o = (state==DONE).
- Accept happens when in_valid_i & in_ready_o & ~flush_i at an edge (call it cycle t). On accept, latch op, tag and the operand magnitudes plus result-sign flags:
  - DIV/REM and MULH: both operands treated as signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - All other ops: unsigned.
- IDLE→CALC on a normal accept; counter loads N:
  - N = XLEN/MUL_STEP for mul ops.
  - N = XLEN for div ops.
- CALC:
  - Mul: each cycle adds MUL_STEP partial products into a 2*XLEN-bit accumulator.
  - Div: each cycle performs one restoring step into an XLEN-bit quotient and remainder.
  - The counter decrements each cycle; CALC→FIX when the counter reaches 1.
- FIX (1 cycle): apply the sign correction (two's-complement negate when the sign flag is set), then select:
  - MUL: low half. MULH/MULHSU/MULHU: high half.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Remainder sign follows the dividend.
  - FIX→DONE.
- Normal latency: out_valid_o first high in cycle t+N+2 (t+34 at XLEN=32, MUL_STEP=1).
- Special cases bypass CALC (IDLE→FIX directly); out_valid_o is high at t+2:
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = rs1.
  - Signed overflow (rs1 = most-negative value, rs2 = all ones, DIV/REM only): DIV result = rs1; REM result = 0.
- DONE:
  - res_o and tag_o hold stable while out_ready_i=0.
  - DONE→IDLE at the edge where out_ready_i=1.
  - No new accept in DONE; worst-case throughput is one op per N+3 cycles.
- flush_i=1 at any edge: state→IDLE and out_valid_o=0 next cycle; any held result is discarded.
  - flush_i has priority over accept and over the DONE handshake.
- Reset mid-operation behaves the same as flush, and additionally clears res_o and tag_o.
- Inputs are sampled only at accept; changes to rs1_i/rs2_i/op_i afterwards have no effect.
- Arithmetic is exact for all XLEN; the accumulator is 2*XLEN+MUL_STEP bits so no intermediate overflow occurs. The counter is clog2(XLEN+1) bits.

Test Plan:
Run with XLEN=32, MUL_STEP=1 unless noted.
1. Multiply, accept at t:
   - MUL 7*0xFFFFFFFD → 0xFFFFFFEB
   - MULH 0x80000000*0x80000000 → 0x40000000
   - MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE
   - MULHSU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFF
   - out_valid_o first high at t+34; repeat with MUL_STEP=4 → t+10.
2. Divide:
   - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF
   - DIVU 0xFFFFFFFF/0x10 → 0x0FFFFFFF; REMU → 0xF
   - out_valid_o first high at t+34; tag_o equals tag_i.
3. Divide by zero, rs1=5, rs2=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → 5; out_valid_o at t+2.
4. Overflow, DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; out_valid_o at t+2.
5. Backpressure:
   - Hold out_ready_i=0 for 10 cycles in DONE → res_o, tag_o, out_valid_o stable; in_ready_o=0.
   - Raise out_ready_i → in_ready_o=1 the next cycle; a second op is then accepted and completes correctly.
6. Flush and reset:
   - flush_i at t+5 → out_valid_o never asserts; in_ready_o=1 at t+6.
   - flush_i in the same cycle as in_valid_i → op not accepted.
   - rst_ni=0 during CALC → next cycle out_valid_o=0, res_o=0, in_ready_o=1.
